rx_frame_writer: RTL

Downstream consumer of the PC receive path. It pops decoded 32-bit payload words from the receive FIFO one at a time and writes them into the frame-buffer memory write port at an auto-incrementing word address. It signals when a complete frame has been stored. It sits between the PC receive block's FIFO read side and the frame-buffer/SRAM controller.

---
 rtl/rx_frame_writer_pkg.sv | 15 +
 rtl/rx_frame_writer.sv | 100 ++++++++++
 2 files changed

// File: rtl/rx_frame_writer_pkg.sv
// Shared types and widths for the receive-side frame writer.
// Holds the FSM state encoding and the data and counter widths.
package rx_frame_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_WRITE
    } wr_state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/rx_frame_writer.sv
// Pops payload words from the receive FIFO and writes them into frame-buffer
// memory at an auto-incrementing, frame-wrapping word address.
module rx_frame_writer
    import rx_frame_writer_pkg::*;
#(
    parameter int FRAME_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_frame_restart,
    input  logic              i_fifo_empty,
    input  logic [WORD_W-1:0] i_fifo_word,
    output logic              o_fifo_read,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_mem_wr,
    input  logic              i_mem_ready,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_words_written
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    wr_state_t         state;
    wr_state_t         state_next;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              restart_pending;
    logic              frame_done;
    logic [CNT_W-1:0]  words_written;
    logic              accept;

    assign accept = (state == ST_WRITE) && i_mem_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_enable && !i_fifo_empty) state_next = ST_POP;
            ST_POP:   state_next = ST_LATCH;
            ST_LATCH: state_next = ST_WRITE;
            ST_WRITE: if (i_mem_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // A restart seen while a write is outstanding is deferred so the in-flight
    // word keeps its address; a restart on the accept cycle still takes effect.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr            <= '0;
            data            <= '0;
            restart_pending <= 1'b0;
            frame_done      <= 1'b0;
            words_written   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (state == ST_LATCH) begin
                data <= i_fifo_word;
            end
            if (accept) begin
                if (words_written != {CNT_W{1'b1}}) begin
                    words_written <= words_written + 1'b1;
                end
                frame_done      <= (addr == LAST_ADDR);
                restart_pending <= 1'b0;
                if (restart_pending || i_frame_restart || addr == LAST_ADDR) begin
                    addr <= '0;
                end else begin
                    addr <= addr + 1'b1;
                end
            end else if (i_frame_restart) begin
                if (state == ST_WRITE) begin
                    restart_pending <= 1'b1;
                end else begin
                    addr <= '0;
                end
            end
        end
    end

    assign o_fifo_read     = (state == ST_POP);
    assign o_mem_wr        = (state == ST_WRITE);
    assign o_busy          = (state != ST_IDLE);
    assign o_mem_addr      = addr;
    assign o_mem_wdata     = data;
    assign o_frame_done    = frame_done;
    assign o_words_written = words_written;

endmodule
